// File: rtl/ltc2641_writer.sv
// Serial DAC writer: takes WIDTH-bit samples on a valid/ready stream and shifts them MSB-first over CS_n/SCK/SDI.
// Frame is (2*WIDTH+1)*HALF cycles of CS_n low plus a CS_HIGH gap; i_tready is low for the whole frame.
module ltc2641_writer #(
  parameter int WIDTH    = 16,
  parameter int clk_freq = 20000000,
  parameter int sck_freq = 10000000,
  parameter int CS_HIGH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic             o_busy,
  output logic             CS_n,
  output logic             SCK,
  output logic             SDI
);

  localparam int HALF    = clk_freq / (2 * sck_freq);
  localparam int CNT_MAX = (HALF > CS_HIGH) ? HALF : CS_HIGH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_HIGH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

  if (HALF < 1) begin : g_half_chk
    $error("ltc2641_writer: clk_freq/(2*sck_freq) must be at least 1");
  end
  if (WIDTH < 12 || WIDTH > 16) begin : g_width_chk
    $error("ltc2641_writer: WIDTH must be within 12..16");
  end
  if (CS_HIGH < 1) begin : g_cs_chk
    $error("ltc2641_writer: CS_HIGH must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             sdi_q, sdi_d;
  logic             tready_q, tready_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    sdi_d    = sdi_q;
    tready_d = 1'b0;

    if (clear) begin
      // Abort lands in GAP so the CS_n high time is still honoured.
      state_d = GAP;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = '0;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      sdi_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cs_n_d = 1'b1;
          sck_d  = 1'b0;
          if (i_tvalid && tready_q) begin
            shreg_d = i_tdata;
            sdi_d   = i_tdata[WIDTH-1];
            cs_n_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = SETUP;
          end else begin
            tready_d = enable;
          end
        end
        SETUP: begin
          if (cnt_q == HALF_LAST) begin
            sck_d   = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (sck_q) begin
              // Falling edge: present the next bit, or finish after the last one.
              sck_d = 1'b0;
              if (bit_q == BIT_LAST) begin
                sdi_d   = 1'b0;
                state_d = HOLD;
              end else begin
                sdi_d   = shreg_q[WIDTH-2];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                bit_d   = bit_q + 1'b1;
              end
            end else begin
              sck_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HALF_LAST) begin
            cs_n_d  = 1'b1;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d    = '0;
            state_d  = IDLE;
            tready_d = enable;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          sdi_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  assign i_tready = tready_q;
  assign o_busy   = busy_q;
  assign CS_n     = cs_n_q;
  assign SCK      = sck_q;
  assign SDI      = sdi_q;

endmodule

// File: tb/tb_ltc2641_writer.sv
// Directed bench for ltc2641_writer: default 16-bit instance (HALF=1) and a 12-bit instance with HALF=4.
module tb_ltc2641_writer;

  logic        clk;
  logic        rst;

  logic        a_clear, a_en, a_tvalid;
  logic [15:0] a_tdata;
  logic        a_tready, a_busy, a_cs_n, a_sck, a_sdi;

  logic        b_clear, b_en, b_tvalid;
  logic [11:0] b_tdata;
  logic        b_tready, b_busy, b_cs_n, b_sck, b_sdi;

  int checks = 0;
  int errors = 0;

  ltc2641_writer #(.WIDTH(16), .clk_freq(20000000), .sck_freq(10000000), .CS_HIGH(2)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .enable(a_en),
    .i_tdata(a_tdata), .i_tvalid(a_tvalid), .i_tready(a_tready), .o_busy(a_busy),
    .CS_n(a_cs_n), .SCK(a_sck), .SDI(a_sdi)
  );

  ltc2641_writer #(.WIDTH(12), .clk_freq(20000000), .sck_freq(2500000), .CS_HIGH(2)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .enable(b_en),
    .i_tdata(b_tdata), .i_tvalid(b_tvalid), .i_tready(b_tready), .o_busy(b_busy),
    .CS_n(b_cs_n), .SCK(b_sck), .SDI(b_sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Follows one frame on instance A; times are relative to the sample after the accept edge.
  task automatic capture_a(input int drop_en_at, output logic ok, output logic [15:0] bits,
                           output int rises, output int pre, output int pre_sck, output int cs_low,
                           output int cs_rise_rel, output int tready_rel);
    logic started, done, prev_sck;
    int rel;
    ok = 0; bits = '0; rises = 0; pre = 0; pre_sck = 0; cs_low = 0;
    cs_rise_rel = -1; tready_rel = -1;
    started = 0; done = 0; prev_sck = 0; rel = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      if (!started) begin
        if (a_cs_n === 1'b0) begin
          started = 1; rel = 0;
        end else begin
          pre++;
          if (a_sck) pre_sck++;
        end
      end else begin
        rel++;
      end
      if (started) begin
        if (rel == drop_en_at) a_en = 1'b0;
        if (a_sck && !prev_sck) begin
          rises++;
          bits = {bits[14:0], a_sdi};
        end
        if (cs_rise_rel < 0 && a_cs_n === 1'b0) cs_low++;
        if (cs_rise_rel < 0 && a_cs_n === 1'b1) cs_rise_rel = rel;
        if (cs_rise_rel >= 0 && a_tready === 1'b1 && tready_rel < 0) begin
          tready_rel = rel; done = 1;
        end
        if (cs_rise_rel >= 0 && rel >= cs_rise_rel + 6) done = 1;
      end
      prev_sck = a_sck;
    end
    ok = done;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a_clear = 0; a_en = 1; a_tvalid = 0; a_tdata = '0;
    b_clear = 0; b_en = 1; b_tvalid = 0; b_tdata = '0;
    repeat (3) tick();
    checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", a_cs_n); end
    checks++; if (a_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", a_sck); end
    checks++; if (a_sdi !== 1'b0) begin errors++; $display("FAIL reset_sdi: got %b expected 0", a_sdi); end
    checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", a_tready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (b_cs_n !== 1'b1) begin errors++; $display("FAIL reset_b_cs_n: got %b expected 1", b_cs_n); end
    rst = 1'b1;
    tick();
    checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %b expected 1", a_tready); end
  endtask

  task automatic test_single_frame;
    logic ok; logic [15:0] bits;
    int rises, pre, pre_sck, cs_low, cs_rise, trdy;
    a_tdata = 16'hA5C3; a_tvalid = 1;
    capture_a(-1, ok, bits, rises, pre, pre_sck, cs_low, cs_rise, trdy);
    a_tvalid = 0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got %b expected 1", ok); end
    checks++; if (bits !== 16'hA5C3) begin errors++; $display("FAIL single_bits: got %h expected a5c3", bits); end
    checks++; if (rises != 16) begin errors++; $display("FAIL single_rises: got %0d expected 16", rises); end
    checks++; if (cs_low != 33) begin errors++; $display("FAIL single_cs_low: got %0d expected 33", cs_low); end
    checks++; if (cs_rise != 33) begin errors++; $display("FAIL single_cs_rise: got %0d expected 33", cs_rise); end
    checks++; if (trdy != 35) begin errors++; $display("FAIL single_tready_rel: got %0d expected 35", trdy); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vec [3] = '{16'h0000, 16'hFFFF, 16'h8001};
    logic ok; logic [15:0] bits;
    int rises, pre, pre_sck, cs_low, cs_rise, trdy, prev_trdy, prev_low, period;
    prev_trdy = 0; prev_low = 0;
    a_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      a_tdata = vec[i];
      capture_a(-1, ok, bits, rises, pre, pre_sck, cs_low, cs_rise, trdy);
      checks++; if (ok !== 1'b1 || bits !== vec[i] || rises != 16) begin
        errors++; $display("FAIL b2b_frame%0d: got ok=%b bits=%h rises=%0d expected ok=1 bits=%h rises=16", i, ok, bits, rises, vec[i]);
      end
      if (i > 0) begin
        period = prev_trdy + 1 + pre;
        checks++; if (period != 36) begin errors++; $display("FAIL b2b_period%0d: got %0d expected 36", i, period); end
        checks++; if (period - prev_low != 3) begin errors++; $display("FAIL b2b_cs_gap%0d: got %0d expected 3", i, period - prev_low); end
      end
      prev_trdy = trdy; prev_low = cs_low;
    end
    a_tvalid = 0;
  endtask

  task automatic test_divider;
    logic [11:0] bits;
    logic started, done, prev_sck, prev_sdi;
    int rises, run, bad_run, bad_sdi, cs_low;
    bits = '0; started = 0; done = 0; prev_sck = 0; prev_sdi = 0;
    rises = 0; run = 0; bad_run = 0; bad_sdi = 0; cs_low = 0;
    b_tdata = 12'h5A3; b_tvalid = 1;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      if (!started) begin
        if (b_cs_n === 1'b0) begin
          started = 1; run = 1; cs_low = 1;
          b_tvalid = 0; b_tdata = 12'hFFF;
        end
      end else if (b_cs_n === 1'b0) begin
        cs_low++;
        if (b_sck !== prev_sck) begin
          if (run != 4) bad_run++;
          run = 1;
          if (b_sck) begin rises++; bits = {bits[10:0], b_sdi}; end
        end else begin
          run++;
        end
        if (b_sdi !== prev_sdi && !(prev_sck && !b_sck)) bad_sdi++;
      end else begin
        if (run != 4) bad_run++;
        done = 1;
      end
      prev_sck = b_sck; prev_sdi = b_sdi;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_timeout: got %b expected 1", done); end
    checks++; if (bits !== 12'h5A3) begin errors++; $display("FAIL div_bits: got %h expected 5a3", bits); end
    checks++; if (rises != 12) begin errors++; $display("FAIL div_rises: got %0d expected 12", rises); end
    checks++; if (bad_run != 0) begin errors++; $display("FAIL div_phase_len: got %0d bad phases expected 0", bad_run); end
    checks++; if (bad_sdi != 0) begin errors++; $display("FAIL div_sdi_edge: got %0d bad changes expected 0", bad_sdi); end
    checks++; if (cs_low != 100) begin errors++; $display("FAIL div_cs_low: got %0d expected 100", cs_low); end
  endtask

  task automatic test_abort;
    logic ok; logic [15:0] bits;
    int rises, pre, pre_sck, cs_low, cs_rise, trdy;
    logic prev_sck;
    rises = 0; prev_sck = 0;
    a_tdata = 16'hFFFF; a_tvalid = 1;
    for (int n = 0; n < 100 && rises < 5; n++) begin
      tick();
      if (a_cs_n === 1'b0) a_tvalid = 0;
      if (a_sck && !prev_sck) rises++;
      prev_sck = a_sck;
    end
    checks++; if (rises != 5) begin errors++; $display("FAIL abort_reach5: got %0d expected 5", rises); end
    a_clear = 1;
    tick();
    checks++; if (a_cs_n !== 1'b1 || a_sck !== 1'b0 || a_sdi !== 1'b0) begin
      errors++; $display("FAIL abort_pins: got cs_n=%b sck=%b sdi=%b expected 1 0 0", a_cs_n, a_sck, a_sdi);
    end
    checks++; if (a_tready !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL abort_state: got tready=%b busy=%b expected 0 1", a_tready, a_busy);
    end
    tick();
    checks++; if (a_tready !== 1'b0 || a_busy !== 1'b1 || a_cs_n !== 1'b1) begin
      errors++; $display("FAIL abort_held: got tready=%b busy=%b cs_n=%b expected 0 1 1", a_tready, a_busy, a_cs_n);
    end
    a_clear = 0; a_tdata = 16'h1234; a_tvalid = 1;
    capture_a(-1, ok, bits, rises, pre, pre_sck, cs_low, cs_rise, trdy);
    a_tvalid = 0;
    checks++; if (pre != 2) begin errors++; $display("FAIL abort_gap: got %0d expected 2", pre); end
    checks++; if (pre_sck != 0) begin errors++; $display("FAIL abort_no_sck: got %0d expected 0", pre_sck); end
    checks++; if (ok !== 1'b1 || bits !== 16'h1234 || rises != 16) begin
      errors++; $display("FAIL abort_next_frame: got ok=%b bits=%h rises=%0d expected 1 1234 16", ok, bits, rises);
    end
  endtask

  task automatic test_clear_priority;
    a_tdata = 16'h7777; a_tvalid = 1; a_clear = 1;
    tick();
    checks++; if (a_cs_n !== 1'b1 || a_busy !== 1'b1 || a_tready !== 1'b0) begin
      errors++; $display("FAIL clear_prio: got cs_n=%b busy=%b tready=%b expected 1 1 0", a_cs_n, a_busy, a_tready);
    end
    a_clear = 0; a_tvalid = 0;
    repeat (2) tick();
    checks++; if (a_tready !== 1'b1 || a_cs_n !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL clear_recover: got tready=%b cs_n=%b busy=%b expected 1 1 0", a_tready, a_cs_n, a_busy);
    end
  endtask

  task automatic test_enable;
    logic ok; logic [15:0] bits;
    int rises, pre, pre_sck, cs_low, cs_rise, trdy;
    a_tvalid = 0; a_en = 0;
    tick();
    a_tvalid = 1; a_tdata = 16'h3C69;
    repeat (3) tick();
    checks++; if (a_tready !== 1'b0 || a_cs_n !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL enable_off: got tready=%b cs_n=%b busy=%b expected 0 1 0", a_tready, a_cs_n, a_busy);
    end
    a_en = 1;
    capture_a(5, ok, bits, rises, pre, pre_sck, cs_low, cs_rise, trdy);
    a_tvalid = 0;
    checks++; if (ok !== 1'b1 || bits !== 16'h3C69 || rises != 16 || cs_low != 33) begin
      errors++; $display("FAIL enable_drop_frame: got ok=%b bits=%h rises=%0d cs_low=%0d expected 1 3c69 16 33", ok, bits, rises, cs_low);
    end
    checks++; if (trdy != -1 || a_tready !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL enable_drop_idle: got trdy_rel=%0d tready=%b busy=%b expected -1 0 0", trdy, a_tready, a_busy);
    end
    a_en = 1;
    tick();
  endtask

  task automatic test_async_reset;
    int rises;
    logic prev_sck;
    rises = 0; prev_sck = 0;
    a_tdata = 16'hF0F0; a_tvalid = 1;
    for (int n = 0; n < 100 && rises < 3; n++) begin
      tick();
      if (a_cs_n === 1'b0) a_tvalid = 0;
      if (a_sck && !prev_sck) rises++;
      prev_sck = a_sck;
    end
    checks++; if (rises != 3 || a_cs_n !== 1'b0) begin
      errors++; $display("FAIL rst_midframe_setup: got rises=%0d cs_n=%b expected 3 0", rises, a_cs_n);
    end
    a_tvalid = 0;
    rst = 1'b0;
    #1;
    checks++; if (a_cs_n !== 1'b1 || a_sck !== 1'b0 || a_sdi !== 1'b0) begin
      errors++; $display("FAIL rst_async_pins: got cs_n=%b sck=%b sdi=%b expected 1 0 0", a_cs_n, a_sck, a_sdi);
    end
    checks++; if (a_tready !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_state: got tready=%b busy=%b expected 0 0", a_tready, a_busy);
    end
    rst = 1'b1;
    tick();
    checks++; if (a_tready !== 1'b1 || a_cs_n !== 1'b1) begin
      errors++; $display("FAIL rst_recover: got tready=%b cs_n=%b expected 1 1", a_tready, a_cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    tick();
    test_back_to_back();
    tick();
    test_divider();
    repeat (4) tick();
    test_abort();
    repeat (4) tick();
    test_clear_priority();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
